fir_out_formatter: RTL and testbench
====================================

// Module: fir_out_formatter
// PURPOSE
//  Downstream stage of the FIR tap/accumulator. Takes each 32-bit signed
//  accumulator result on a one-cycle strobe and scales it with an arithmetic right shift.
//  Rounds the result, saturates it to 24-bit signed audio and buffers it in a small FIFO.
//  The I2S/output serializer drains the FIFO through a valid/ready handshake.
// PARAMETERS
//  SHIFT       8   arithmetic right shift applied to acc_data (0..16)
//  FIFO_DEPTH  4   output FIFO entries, power of two, 2..16
//  CNT_W       3   width of fifo_level; equals log2(FIFO_DEPTH)+1
// PORTS
//  clk          in   1      system clock
//  reset_n      in   1      asynchronous active-low reset
//  acc_valid    in   1      strobe: acc_data holds a finished accumulator sum
//  acc_data     in   32     signed accumulator result
//  out_ready    in   1      downstream can accept out_data this cycle
//  out_valid    out  1      out_data holds a valid sample (FIFO not empty)
//  out_data     out  24     signed formatted sample, head of FIFO
//  fifo_level   out  CNT_W  number of entries in the FIFO
//  sat_flag     out  1      sticky flag: at least one sample was clipped
//  ovf_flag     out  1      sticky flag: at least one sample was dropped (FIFO full)
//  clr_flags    in   1      synchronous clear of sat_flag and ovf_flag
// BEHAVIOUR
//  Reset: all outputs are 0, the FIFO is empty, and the pipeline valid bits are 0.
//   Reset is asynchronous and can assert mid-operation; any data in flight is discarded.
//  Stage 1 (cycle after acc_valid):
//   s1 = sign-extend(acc_data) to 33 bits, >>> SHIFT, plus a rounding term (see CONFIGURATION).
//   The sum is computed in 33 bits so the round-up can never wrap.
//  Stage 2 (the following cycle):
//   Saturate s1 to the 24-bit range [0x800000, 0x7FFFFF].
//   If clipping occurs, set sat_flag.
//   The result is then pushed into the FIFO.
//  Latency: acc_valid at cycle N leads to a FIFO write at the N+2 edge.
//   On an empty FIFO, out_valid rises at N+2.
//  acc_valid pulses may arrive on consecutive cycles; the pipeline is fully pipelined.
//  FIFO read is first-word-fall-through: out_data is always the head entry.
//   A pop happens when out_valid && out_ready.
//   out_data and out_valid must be held stable while out_valid && !out_ready.
//  Push while full:
//   If a pop also happens that cycle, the push is accepted and the level is unchanged.
//   Otherwise the sample is dropped, ovf_flag is set, and the FIFO contents are untouched.
//  Pop while empty: ignored; out_valid stays 0.
//  Simultaneous push and pop on a non-full, non-empty FIFO: the level is unchanged.
//  The write and read pointers wrap modulo FIFO_DEPTH.
//  fifo_level ranges over 0..FIFO_DEPTH.
//  Flags:
//   sat_flag and ovf_flag are sticky until clr_flags.
//   If clr_flags and a new set event occur in the same cycle, the flag is set (set wins).
// CONFIGURATION
//  FMT_ROUND_EN defined:
//   Round half up: add 1<<(SHIFT-1) before the shift when SHIFT>0.
//   With SHIFT=0 there is no rounding.
//  FMT_ROUND_EN undefined:
//   Plain truncation toward negative infinity (arithmetic shift only).
//   The stage-1 register is still present, so latency is the same 2 cycles.
// TESTING (SHIFT=8, FIFO_DEPTH=4, FMT_ROUND_EN defined unless noted)
//  1. Rounding:
//   acc_data=0x00001280 -> out_data=0x000013 at N+2.
//   The same input with FMT_ROUND_EN undefined -> 0x000012.
//  2. Saturation:
//   0x7FFFFF80 -> 0x7FFFFF with sat_flag=1 (the round-up overflow is caught).
//   0x80000000 -> 0x800000 with sat_flag unchanged.
//  3. Back-pressure:
//   Send 5 consecutive acc_valid pulses with out_ready=0.
//   Expect fifo_level=4, ovf_flag=1, and the FIFO to hold samples 1..4 in order.
//  4. Full push and pop in the same cycle:
//   With the FIFO full, drive out_ready=1 and a push arriving together.
//   Expect the level to stay 4, ovf_flag=0, and the pop returning the oldest sample.
//  5. Flag clear:
//   Assert clr_flags in the same cycle a clipped sample is written -> sat_flag stays 1.
//   Assert clr_flags on the next cycle -> sat_flag=0.
//  6. Reset mid-stream:
//   Assert reset_n=0 with 3 entries buffered and 2 samples in flight.
//   Immediately expect out_valid=0, fifo_level=0 and both flags 0.
//   No stale samples may appear after release.

Source files
------------

// File: rtl/fir_out_formatter.sv
// ---------------------------------------------------------------------------------------------
// fir_out_formatter
//
// Output stage behind the FIR tap/accumulator. Each finished 32-bit signed accumulator sum
// goes through these steps:
//   1. It is arithmetic-shifted right by SHIFT, with optional round-half-up.
//   2. It is saturated to 24-bit signed audio.
//   3. It is queued in a small first-word-fall-through FIFO.
// The serializer drains that FIFO through a valid/ready handshake.
//
// Pipeline: acc_valid_i sampled at edge N+1 -> stage-1 register; edge N+2 -> FIFO write.
//
// Build option:
//   FMT_ROUND_EN  defined   : round half up (add 1 << (SHIFT-1) before shifting, SHIFT > 0)
//                 undefined : plain truncation toward negative infinity
//
// Parameters:
//   SHIFT       arithmetic right shift applied to the accumulator (0..16)
//   FIFO_DEPTH  FIFO entries, power of two (2..16)
//   CNT_W       width of fifo_level_o, log2(FIFO_DEPTH)+1
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   acc_valid_i   one-cycle strobe, acc_data_i holds a finished sum
//   acc_data_i    signed accumulator result (32 bit)
//   out_ready_i   downstream accepts out_data_o this cycle
//   out_valid_o   FIFO not empty, out_data_o is valid
//   out_data_o    head-of-FIFO formatted sample (24 bit signed), 0 when empty
//   fifo_level_o  number of buffered samples, 0..FIFO_DEPTH
//   sat_flag_o    sticky: a sample was clipped
//   ovf_flag_o    sticky: a sample was dropped because the FIFO was full
//   clr_flags_i   synchronous clear of both sticky flags (a same-cycle set wins)
// ---------------------------------------------------------------------------------------------
module fir_out_formatter #(
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              acc_valid_i,
    input  logic [31:0]       acc_data_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [23:0]       out_data_o,
    output logic [CNT_W-1:0]  fifo_level_o,
    output logic              sat_flag_o,
    output logic              ovf_flag_o,
    input  logic              clr_flags_i
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LevelFull = CNT_W'(FIFO_DEPTH);

    // -----------------------------------------------------------------------------------------
    // Stage 1: scale (and optionally round) in 33 bits so the round-up cannot wrap
    // -----------------------------------------------------------------------------------------
    logic signed [32:0] acc_ext;
    logic signed [32:0] s1_d, s1_q;
    logic               s1_valid_d, s1_valid_q;

    assign acc_ext = {acc_data_i[31], acc_data_i};

`ifdef FMT_ROUND_EN
    // (1 << SHIFT) >> 1 equals 1 << (SHIFT-1) and collapses to 0 for SHIFT == 0.
    localparam logic signed [32:0] RoundTerm = 33'((64'd1 << SHIFT) >> 1);
    assign s1_d = (acc_ext + RoundTerm) >>> SHIFT;
`else
    assign s1_d = acc_ext >>> SHIFT;
`endif

    assign s1_valid_d = acc_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Stage 2: saturate to 24-bit signed
    // -----------------------------------------------------------------------------------------
    logic        in_range;
    logic [23:0] sat_data;
    logic        clip;

    // The value fits in 24 bits when bits 32..23 are all copies of the sign.
    assign in_range = (&s1_q[32:23]) | (~|s1_q[32:23]);
    assign sat_data = in_range   ? s1_q[23:0]  :
                      s1_q[32]   ? 24'h800000  : 24'h7FFFFF;
    assign clip     = s1_valid_q & ~in_range;

    // -----------------------------------------------------------------------------------------
    // Output FIFO (first-word-fall-through)
    // -----------------------------------------------------------------------------------------
    logic [23:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_d, wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0] level_d, level_q;
    logic             empty, full;
    logic             push, pop, drop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LevelFull);
    assign pop   = ~empty & out_ready_i;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign push  = s1_valid_q & (~full | pop);
    assign drop  = s1_valid_q & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + CNT_W'(1);
            2'b01:   level_d = level_q - CNT_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the read side is masked whenever the FIFO is empty.
    // On a full push+pop the write lands in the slot being vacated by the head.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sat_data;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Sticky flags: a set event in the clear cycle wins
    // -----------------------------------------------------------------------------------------
    logic sat_d, sat_q;
    logic ovf_d, ovf_q;

    always_comb begin
        sat_d = (sat_q & ~clr_flags_i) | clip;
        ovf_d = (ovf_q & ~clr_flags_i) | drop;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
            ovf_q <= ovf_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    assign out_valid_o  = ~empty;
    assign out_data_o   = empty ? 24'h000000 : mem_q[rd_ptr_q];
    assign fifo_level_o = level_q;
    assign sat_flag_o   = sat_q;
    assign ovf_flag_o   = ovf_q;

endmodule

// File: tb/tb_fir_out_formatter.sv
// ---------------------------------------------------------------------------------------------
// tb_fir_out_formatter
//
// Directed bench for fir_out_formatter (SHIFT=8, FIFO_DEPTH=4). Expected samples come from a
// behavioural formatter model and are queued when a sample is driven. A negedge monitor pops
// the queue whenever the DUT hands a sample over and also checks that the head is held
// stable under back-pressure.
// ---------------------------------------------------------------------------------------------
module tb_fir_out_formatter;

    localparam int unsigned SHIFT      = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = 3;

    logic              clk;
    logic              rst_n;
    logic              acc_valid;
    logic [31:0]       acc_data;
    logic              out_ready;
    logic              out_valid;
    logic [23:0]       out_data;
    logic [CNT_W-1:0]  fifo_level;
    logic              sat_flag;
    logic              ovf_flag;
    logic              clr_flags;

    int ncmp = 0;
    int nerr = 0;

    logic [23:0] sb_q [$];

    fir_out_formatter #(
        .SHIFT      (SHIFT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .acc_valid_i  (acc_valid),
        .acc_data_i   (acc_data),
        .out_ready_i  (out_ready),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .fifo_level_o (fifo_level),
        .sat_flag_o   (sat_flag),
        .ovf_flag_o   (ovf_flag),
        .clr_flags_i  (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural formatter: returns {clipped, sample}.
    function automatic logic [24:0] model(input logic [31:0] a);
        longint v;
        v = longint'($signed(a));
`ifdef FMT_ROUND_EN
        v = v + (longint'(1) << (SHIFT - 1));
`endif
        v = v >>> SHIFT;
        if (v > 64'sd8388607)  return {1'b1, 24'h7FFFFF};
        if (v < -64'sd8388608) return {1'b1, 24'h800000};
        return {1'b0, v[23:0]};
    endfunction

    function automatic logic model_clip(input logic [31:0] a);
        logic [24:0] m;
        m = model(a);
        return m[24];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves acc_valid high so consecutive calls make back-to-back strobes.
    task automatic drive(input logic [31:0] d, input bit dropped);
        logic [24:0] m;
        m = model(d);
        acc_valid = 1'b1;
        acc_data  = d;
        if (!dropped) sb_q.push_back(m[23:0]);
        tick();
    endtask

    task automatic send(input logic [31:0] d);
        drive(d, 1'b0);
        acc_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && fifo_level != '0; i++) tick();
        out_ready = 1'b0;
        chk("drain_level", 32'(fifo_level), 32'd0);
    endtask

    // Scoreboard / hold monitor
    logic        prev_stall = 1'b0;
    logic [23:0] prev_data  = '0;
    logic [23:0] exp_head;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                ncmp++;
                assert (out_valid === 1'b1 && out_data === prev_data) else begin
                    nerr++;
                    $error("FAIL hold: observed valid=%0b data=%06h expected valid=1 data=%06h",
                           out_valid, out_data, prev_data);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                ncmp++;
                if (sb_q.size() == 0) begin
                    nerr++;
                    $error("FAIL pop_unexpected: observed %06h expected no sample", out_data);
                end else begin
                    exp_head = sb_q.pop_front();
                    assert (out_data === exp_head) else begin
                        nerr++;
                        $error("FAIL pop_data: observed %06h expected %06h", out_data, exp_head);
                    end
                end
            end
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_data  = out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] exp_round;

    initial begin
        rst_n     = 1'b0;
        acc_valid = 1'b0;
        acc_data  = '0;
        out_ready = 1'b0;
        clr_flags = 1'b0;
`ifdef FMT_ROUND_EN
        exp_round = 32'h13;
`else
        exp_round = 32'h12;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_data",  32'(out_data), 32'd0);
        chk("rst_sat",   32'(sat_flag), 32'd0);
        chk("rst_ovf",   32'(ovf_flag), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1. Rounding and latency
        send(32'h00001280);
        chk("lat_n1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat_n2_valid", 32'(out_valid), 32'd1);
        chk("round_data",   32'(out_data), exp_round);
        chk("round_level",  32'(fifo_level), 32'd1);
        drain();

        // 2. Saturation
        send(32'h7FFFFF80);
        tick();
        chk("satpos_data", 32'(out_data), 32'h7FFFFF);
        chk("satpos_flag", 32'(sat_flag), 32'(model_clip(32'h7FFFFF80)));
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("sat_cleared", 32'(sat_flag), 32'd0);
        send(32'h80000000);
        tick();
        chk("satneg_level", 32'(fifo_level), 32'd2);
        chk("satneg_flag",  32'(sat_flag), 32'd0);
        chk("satneg_head",  32'(out_data), 32'h7FFFFF);
        drain();

        // 3. Back-pressure: five strobes, the fifth is dropped
        chk("bp_ovf_before", 32'(ovf_flag), 32'd0);
        for (int i = 0; i < 5; i++) drive(32'((i + 1) << 8), (i == 4));
        acc_valid = 1'b0;
        tick();
        chk("bp_level", 32'(fifo_level), 32'd4);
        chk("bp_ovf",   32'(ovf_flag), 32'd1);
        chk("bp_head",  32'(out_data), 32'h000001);

        // 4. Full FIFO: push and pop in the same cycle
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("fp_ovf_clr", 32'(ovf_flag), 32'd0);
        send(32'h00000600);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fp_level", 32'(fifo_level), 32'd4);
        chk("fp_ovf",   32'(ovf_flag), 32'd0);
        chk("fp_head",  32'(out_data), 32'h000002);
        drain();

        // 5. Flag clear racing a clipped write
        send(32'h7FFFFF80);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("clr_race_sat", 32'(sat_flag), 32'(model_clip(32'h7FFFFF80)));
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("clr_next_sat", 32'(sat_flag), 32'd0);
        drain();

        // 6. Reset with three buffered entries and two samples in flight
        drive(32'h7FFFFF80, 1'b0);
        drive(32'h00000300, 1'b0);
        drive(32'h00000400, 1'b0);
        drive(32'h00000500, 1'b0);
        chk("prerst_level", 32'(fifo_level), 32'd3);
        chk("prerst_sat",   32'(sat_flag), 32'(model_clip(32'h7FFFFF80)));
        acc_data = 32'h00000600;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_sat",   32'(sat_flag), 32'd0);
        chk("midrst_ovf",   32'(ovf_flag), 32'd0);
        sb_q.delete();
        acc_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("postrst_valid", 32'(out_valid), 32'd0);
        chk("postrst_level", 32'(fifo_level), 32'd0);
        out_ready = 1'b1;
        repeat (2) tick();
        chk("postrst_ready_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        send(32'h00001280);
        tick();
        chk("postrst_new_valid", 32'(out_valid), 32'd1);
        chk("postrst_new_data",  32'(out_data), exp_round);
        drain();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
